o3_tree_pipe: RTL and testbench

//  Parametrised, pipelined N-input OR reduction built from 3-input OR levels.
//  - One register stage per tree level; valid/ready handshake on input and output.
//  - Full-pipeline stall under backpressure.
//  - Successor to the fixed 3-input OR cell, for wide flag/interrupt aggregation
//    in StdCellLib-based designs where a single combinational OR would break timing.

---
 rtl/o3_tree_pipe.sv | 107 ++++++++++
 tb/tb_o3_tree_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/o3_tree_pipe.sv
// o3_tree_pipe: pipelined WIDTH-input OR reduction, one registered 3-input OR level per stage.
// Define O3_TREE_PIPE_STICKY_EN to build the sticky result flag qs (cleared by clr).
module o3_tree_pipe #(
  parameter int WIDTH = 9
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic [WIDTH-1:0] i,
  input  logic             i_vld,
  output logic             i_rdy,
  output logic             q,
  output logic             q_vld,
  input  logic             q_rdy,
  input  logic             clr,
  output logic             qs
);

  function automatic int calc_levels(input int w);
    int l;
    int p;
    l = 1;
    p = 3;
    for (int n = 0; n < 8; n++) begin
      if (p < w) begin
        p = p * 3;
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH);
  localparam int PAD    = 3 ** LEVELS;

  logic           en;
  logic [PAD-1:0] padded;

  assign en    = ~q_vld | q_rdy;
  assign i_rdy = en;

  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = i;
  end

  // Level k narrows its source by three; the whole pipeline shifts together on en.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int W = 3 ** (LEVELS - k);

    logic [3*W-1:0] src;
    logic           src_v;
    logic [W-1:0]   red;
    logic [W-1:0]   d;
    logic           v;

    if (k == 1) begin : g_first
      assign src   = padded;
      assign src_v = i_vld;
    end else begin : g_next
      assign src   = g_lvl[k-1].d;
      assign src_v = g_lvl[k-1].v;
    end

    always_comb begin
      red = '0;
      for (int j = 0; j < W; j++) begin
        red[j] = |src[3*j +: 3];
      end
    end

    always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
        d <= '0;
        v <= 1'b0;
      end else if (en) begin
        d <= red;
        v <= src_v;
      end
    end
  end

  assign q     = g_lvl[LEVELS].d[0];
  assign q_vld = g_lvl[LEVELS].v;

`ifdef O3_TREE_PIPE_STICKY_EN
  logic s;

  // A delivered 1 takes priority over a clear at the same edge.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      s <= 1'b0;
    end else if (q_vld && q_rdy && q) begin
      s <= 1'b1;
    end else if (clr) begin
      s <= 1'b0;
    end
  end

  assign qs = s;
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign qs         = 1'b0;
`endif

endmodule

// File: tb/tb_o3_tree_pipe.sv
// tb_o3_tree_pipe: drives three widths (9, 10, 27) from one stimulus stream and checks each
// against a queue-based reference built from acceptance order and enabled-cycle counting.
module tb_o3_tree_pipe;

  logic        ck = 1'b0;
  logic        nrst;
  logic [26:0] stim;
  logic        i_vld;
  logic        q_rdy;
  logic        clr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 ck = ~ck;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [26:0] v, input logic vld, input logic rdy,
                               input logic c);
    stim  = v;
    i_vld = vld;
    q_rdy = rdy;
    clr   = c;
    @(posedge ck);
    #1;
  endtask

  // Each lane: a vector accepted on the c-th enabled edge is due on q once c+L enabled edges occurred.
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W = (g == 0) ? 9 : ((g == 1) ? 10 : 27);
    localparam int L = (g == 0) ? 2 : 3;

    logic q;
    logic q_vld;
    logic i_rdy;
    logic qs;

    bit val_q[$];
    int due_q[$];
    int en_cnt  = 0;
    bit exp_vld = 1'b0;
    bit exp_en  = 1'b1;
    bit exp_s   = 1'b0;

    o3_tree_pipe #(.WIDTH(W)) dut (
      .ck    (ck),
      .nrst  (nrst),
      .i     (stim[W-1:0]),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .q     (q),
      .q_vld (q_vld),
      .q_rdy (q_rdy),
      .clr   (clr),
      .qs    (qs)
    );

    always @(negedge ck) begin
      exp_vld = (due_q.size() > 0) && (due_q[0] == en_cnt);
      exp_en  = !exp_vld || q_rdy;
      checkOutput($sformatf("w%0d q_vld", W), q_vld, exp_vld);
      checkOutput($sformatf("w%0d i_rdy", W), i_rdy, exp_en);
      checkOutput($sformatf("w%0d qs", W), qs, exp_s);
      if (exp_vld) checkOutput($sformatf("w%0d q", W), q, val_q[0]);
    end

    always @(posedge ck or negedge nrst) begin
      if (!nrst) begin
        val_q.delete();
        due_q.delete();
        en_cnt  = 0;
        exp_vld = 1'b0;
        exp_en  = 1'b1;
        exp_s   = 1'b0;
      end else begin
`ifdef O3_TREE_PIPE_STICKY_EN
        if (exp_vld && q_rdy && val_q[0]) exp_s = 1'b1;
        else if (clr) exp_s = 1'b0;
`endif
        if (exp_vld && q_rdy) begin
          void'(val_q.pop_front());
          void'(due_q.pop_front());
        end
        if (exp_en) begin
          if (i_vld) begin
            val_q.push_back(|stim[W-1:0]);
            due_q.push_back(en_cnt + L);
          end
          en_cnt++;
        end
      end
    end
  end

  initial begin
    logic [26:0] v;

    // Reset held with a valid all-ones vector presented
    nrst  = 1'b0;
    stim  = '1;
    i_vld = 1'b1;
    q_rdy = 1'b1;
    clr   = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    nrst = 1'b1;
    applyStimulus('1, 1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Walking one across all 27 bits, then zero, back to back
    for (int b = 0; b < 27; b++) begin
      v = 27'd1 << b;
      applyStimulus(v, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Backpressure: stall five cycles mid-stream
    applyStimulus(27'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(27'h4000000, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus(27'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(27'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(27'h1, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Bubbles with bit 9 set
    for (int n = 0; n < 8; n++) begin
      applyStimulus(27'h200, n[0], 1'b1, 1'b0);
    end
    repeat (4) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Mid-flight reset: half-cycle pulse with three vectors in the pipe
    applyStimulus(27'h200, 1'b1, 1'b1, 1'b0);
    applyStimulus(27'h001, 1'b1, 1'b1, 1'b0);
    applyStimulus(27'h100, 1'b1, 1'b1, 1'b0);
    i_vld = 1'b0;
    #1;
    nrst = 1'b0;
    #1;
    checkOutput("rst w9 q_vld", lane[0].q_vld, 1'b0);
    checkOutput("rst w10 q_vld", lane[1].q_vld, 1'b0);
    checkOutput("rst w27 q_vld", lane[2].q_vld, 1'b0);
    #3;
    nrst = 1'b1;
    @(posedge ck);
    #1;
    repeat (5) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Sticky: deliver 0, 1, 0; clear overlapping a 1; clear alone
    applyStimulus(27'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(27'h1, 1'b1, 1'b1, 1'b0);
    applyStimulus(27'h0, 1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus('0, 1'b0, 1'b1, 1'b0);
    applyStimulus(27'h2, 1'b1, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b1);
    applyStimulus('0, 1'b0, 1'b1, 1'b1);
    repeat (3) applyStimulus('0, 1'b0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b1);
    repeat (2) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with sparse vectors, random backpressure and clears
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) v = '0;
      else v = 27'd1 << $urandom_range(0, 26);
      applyStimulus(v, ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0));
    end
    repeat (6) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
